id_ex_stage: RTL and testbench

- Pipeline register between instruction decode and the ALU.
- Captures decoded operands and control, and generates the 4-bit ALU control code from opcode/funct.
- Extends the immediate and applies EX/MEM and MEM/WB forwarding, so the ALU receives final a/b operands.
- Supports load-use stall (hold) and branch flush (bubble insertion).

---
 rtl/id_ex_if.sv | 67 ++++++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// Bundle of ID-side inputs, hazard/forwarding inputs and EX-side outputs
// around the ID/EX pipeline register.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [5:0]        id_opcode;
  logic [5:0]        id_funct;
  logic [15:0]       id_imm;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              id_reg_dst;
  logic              id_alu_src;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_mem_to_reg;
  logic              id_reg_write;
  logic              id_branch;
  logic              exmem_reg_write;
  logic [REG_W-1:0]  exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [REG_W-1:0]  memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic              ex_valid;
  logic [3:0]        ex_alu_ctrl;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_write_reg;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;
  logic              ex_reg_write;
  logic              ex_branch;
  logic              ex_illegal;

  modport master (
    output stall, flush, id_valid, id_opcode, id_funct, id_imm,
           id_rs_data, id_rt_data, id_rs, id_rt, id_rd,
           id_reg_dst, id_alu_src, id_mem_read, id_mem_write,
           id_mem_to_reg, id_reg_write, id_branch,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  ex_valid, ex_alu_ctrl, ex_a, ex_b, ex_store_data, ex_write_reg,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
           ex_branch, ex_illegal
  );

  modport slave (
    input  stall, flush, id_valid, id_opcode, id_funct, id_imm,
           id_rs_data, id_rt_data, id_rs, id_rt, id_rd,
           id_reg_dst, id_alu_src, id_mem_read, id_mem_write,
           id_mem_to_reg, id_reg_write, id_branch,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output ex_valid, ex_alu_ctrl, ex_a, ex_b, ex_store_data, ex_write_reg,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
           ex_branch, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: ALU-control decode, immediate extension and
// EX/MEM, MEM/WB operand forwarding in front of the ALU.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic    clk,
  input logic    rst_n,
  id_ex_if.slave bus
);

  localparam logic [3:0] ALU_ADD = 4'b0010;

  logic [3:0]        dec_ctrl;
  logic              dec_legal;
  logic [DATA_W-1:0] dec_imm_ext;

  logic              valid_q;
  logic [3:0]        alu_ctrl_q;
  logic              illegal_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_ext_q;
  logic [REG_W-1:0]  write_reg_q;
  logic              alu_src_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              mem_to_reg_q;
  logic              reg_write_q;
  logic              branch_q;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  always_comb begin
    dec_ctrl  = 4'b1111;
    dec_legal = 1'b1;
    case (bus.id_opcode)
      6'b000000: begin
        case (bus.id_funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          default:   dec_legal = 1'b0;
        endcase
      end
      6'b100011, 6'b101011, 6'b001000: dec_ctrl = 4'b0010;
      6'b000100: dec_ctrl = 4'b0110;
      6'b001100: dec_ctrl = 4'b0000;
      6'b001101: dec_ctrl = 4'b0001;
      6'b001010: dec_ctrl = 4'b0111;
      default:   dec_legal = 1'b0;
    endcase
  end

  // andi/ori take a zero-extended immediate, everything else sign-extends
  assign dec_imm_ext = (bus.id_opcode == 6'b001100 || bus.id_opcode == 6'b001101)
                     ? {{(DATA_W-16){1'b0}}, bus.id_imm}
                     : {{(DATA_W-16){bus.id_imm[15]}}, bus.id_imm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || 1'b0) begin
      valid_q      <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      illegal_q    <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_ext_q    <= '0;
      write_reg_q  <= '0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      branch_q     <= 1'b0;
    end else if (bus.flush || (!bus.stall && !bus.id_valid)) begin
      valid_q      <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      illegal_q    <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_ext_q    <= '0;
      write_reg_q  <= '0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      branch_q     <= 1'b0;
    end else if (!bus.stall) begin
      valid_q      <= 1'b1;
      alu_ctrl_q   <= dec_ctrl;
      illegal_q    <= !dec_legal;
      rs_q         <= bus.id_rs;
      rt_q         <= bus.id_rt;
      rs_data_q    <= bus.id_rs_data;
      rt_data_q    <= bus.id_rt_data;
      imm_ext_q    <= dec_imm_ext;
      write_reg_q  <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      alu_src_q    <= bus.id_alu_src;
      // an undecodable instruction must not touch registers or memory
      mem_read_q   <= bus.id_mem_read   && dec_legal;
      mem_write_q  <= bus.id_mem_write  && dec_legal;
      mem_to_reg_q <= bus.id_mem_to_reg && dec_legal;
      reg_write_q  <= bus.id_reg_write  && dec_legal;
      branch_q     <= bus.id_branch;
    end
  end

  always_comb begin
    fwd_rs = rs_data_q;
    if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rs_q)
      fwd_rs = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rs_q)
      fwd_rs = bus.memwb_result;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rt_q)
      fwd_rt = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rt_q)
      fwd_rt = bus.memwb_result;
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_alu_ctrl   = alu_ctrl_q;
  assign bus.ex_illegal    = illegal_q;
  assign bus.ex_a          = fwd_rs;
  assign bus.ex_b          = alu_src_q ? imm_ext_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_write_reg  = write_reg_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_mem_to_reg = mem_to_reg_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_branch     = branch_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: decode, immediates, forwarding,
// stall/flush priority and asynchronous reset.
module tb_id_ex_stage;

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd;
    logic [6:0]  ctl;     // reg_dst,alu_src,mem_read,mem_write,mem_to_reg,reg_write,branch
    logic        em_rw;
    logic [4:0]  em_rd;
    logic        mw_rw;
    logic [4:0]  mw_rd;
    logic [3:0]  e_ctrl;
    logic [31:0] e_a, e_b, e_st;
    logic [4:0]  e_wr;
    logic        e_ill;
    logic [4:0]  e_c5;    // mem_read,mem_write,mem_to_reg,reg_write,branch
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   tag = 0;
  vec_t vecs[$];

  id_ex_if #(.DATA_W(32), .REG_W(5)) bus ();
  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  function automatic vec_t v(logic valid, logic [5:0] op, logic [5:0] fn, logic [15:0] imm,
                             logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                             logic [31:0] rsd, logic [31:0] rtd, logic [6:0] ctl,
                             logic em_rw, logic [4:0] em_rd, logic mw_rw, logic [4:0] mw_rd,
                             logic [3:0] e_ctrl, logic [31:0] e_a, logic [31:0] e_b,
                             logic [31:0] e_st, logic [4:0] e_wr, logic e_ill, logic [4:0] e_c5);
    vec_t r;
    r.valid = valid; r.op = op; r.fn = fn; r.imm = imm;
    r.rs = rs; r.rt = rt; r.rd = rd; r.rsd = rsd; r.rtd = rtd; r.ctl = ctl;
    r.em_rw = em_rw; r.em_rd = em_rd; r.mw_rw = mw_rw; r.mw_rd = mw_rd;
    r.e_ctrl = e_ctrl; r.e_a = e_a; r.e_b = e_b; r.e_st = e_st;
    r.e_wr = e_wr; r.e_ill = e_ill; r.e_c5 = e_c5;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (case %0d): got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    bus.id_valid      = x.valid;
    bus.id_opcode     = x.op;
    bus.id_funct      = x.fn;
    bus.id_imm        = x.imm;
    bus.id_rs         = x.rs;
    bus.id_rt         = x.rt;
    bus.id_rd         = x.rd;
    bus.id_rs_data    = x.rsd;
    bus.id_rt_data    = x.rtd;
    {bus.id_reg_dst, bus.id_alu_src, bus.id_mem_read, bus.id_mem_write,
     bus.id_mem_to_reg, bus.id_reg_write, bus.id_branch} = x.ctl;
    bus.exmem_reg_write = x.em_rw;
    bus.exmem_rd        = x.em_rd;
    bus.memwb_reg_write = x.mw_rw;
    bus.memwb_rd        = x.mw_rd;
  endtask

  task automatic check_vec(vec_t x);
    chk("ex_valid",      32'(bus.ex_valid),      32'(x.valid));
    chk("ex_alu_ctrl",   32'(bus.ex_alu_ctrl),   32'(x.e_ctrl));
    chk("ex_a",          bus.ex_a,               x.e_a);
    chk("ex_b",          bus.ex_b,               x.e_b);
    chk("ex_store_data", bus.ex_store_data,      x.e_st);
    chk("ex_write_reg",  32'(bus.ex_write_reg),  32'(x.e_wr));
    chk("ex_illegal",    32'(bus.ex_illegal),    32'(x.e_ill));
    chk("ex_ctrl_bits",  32'({bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg,
                              bus.ex_reg_write, bus.ex_branch}), 32'(x.e_c5));
  endtask

  initial begin
    // R-type / I-type decode, immediates, forwarding, illegal, bubble
    vecs.push_back(v(1, 6'h00, 6'h22, 16'h0000, 8, 9, 10, 10, 3, 7'b1000010, 0, 0, 0, 0,
                     4'b0110, 10, 3, 3, 10, 0, 5'b00010));
    vecs.push_back(v(1, 6'h0C, 6'h00, 16'h8001, 1, 4, 0, 7, 9, 7'b0100010, 0, 0, 0, 0,
                     4'b0000, 7, 32'h0000_8001, 9, 4, 0, 5'b00010));
    vecs.push_back(v(1, 6'h08, 6'h00, 16'h8001, 1, 4, 0, 7, 9, 7'b0100010, 0, 0, 0, 0,
                     4'b0010, 7, 32'hFFFF_8001, 9, 4, 0, 5'b00010));
    vecs.push_back(v(1, 6'h00, 6'h20, 16'h0000, 5, 5, 3, 1, 2, 7'b1000010, 1, 5, 1, 5,
                     4'b0010, 32'h11, 32'h11, 32'h11, 3, 0, 5'b00010));
    vecs.push_back(v(1, 6'h00, 6'h20, 16'h0000, 5, 5, 3, 1, 2, 7'b1000010, 1, 0, 1, 5,
                     4'b0010, 32'h22, 32'h22, 32'h22, 3, 0, 5'b00010));
    vecs.push_back(v(1, 6'h00, 6'h20, 16'h0000, 0, 0, 3, 32'h33, 32'h44, 7'b1000010, 1, 0, 1, 0,
                     4'b0010, 32'h33, 32'h44, 32'h44, 3, 0, 5'b00010));
    vecs.push_back(v(1, 6'h00, 6'h20, 16'h0000, 6, 7, 3, 1, 2, 7'b1000010, 1, 6, 1, 7,
                     4'b0010, 32'h11, 32'h22, 32'h22, 3, 0, 5'b00010));
    vecs.push_back(v(1, 6'h00, 6'h20, 16'h0000, 5, 5, 3, 1, 2, 7'b1000010, 0, 5, 0, 5,
                     4'b0010, 1, 2, 2, 3, 0, 5'b00010));
    vecs.push_back(v(1, 6'h00, 6'h24, 16'h0000, 1, 2, 3, 1, 2, 7'b1000010, 0, 0, 0, 0,
                     4'b0000, 1, 2, 2, 3, 0, 5'b00010));
    vecs.push_back(v(1, 6'h00, 6'h25, 16'h0000, 1, 2, 3, 1, 2, 7'b1000010, 0, 0, 0, 0,
                     4'b0001, 1, 2, 2, 3, 0, 5'b00010));
    vecs.push_back(v(1, 6'h00, 6'h2A, 16'h0000, 1, 2, 3, 1, 2, 7'b1000010, 0, 0, 0, 0,
                     4'b0111, 1, 2, 2, 3, 0, 5'b00010));
    vecs.push_back(v(1, 6'h23, 6'h00, 16'h0004, 1, 4, 0, 100, 9, 7'b0110110, 0, 0, 0, 0,
                     4'b0010, 100, 4, 9, 4, 0, 5'b10110));
    vecs.push_back(v(1, 6'h2B, 6'h00, 16'hFFFC, 1, 4, 0, 100, 9, 7'b0101000, 0, 0, 0, 0,
                     4'b0010, 100, 32'hFFFF_FFFC, 9, 4, 0, 5'b01000));
    vecs.push_back(v(1, 6'h04, 6'h00, 16'h0003, 1, 4, 0, 5, 5, 7'b0000001, 0, 0, 0, 0,
                     4'b0110, 5, 5, 5, 4, 0, 5'b00001));
    vecs.push_back(v(1, 6'h0D, 6'h00, 16'hFFFF, 1, 4, 0, 7, 9, 7'b0100010, 0, 0, 0, 0,
                     4'b0001, 7, 32'h0000_FFFF, 9, 4, 0, 5'b00010));
    vecs.push_back(v(1, 6'h0A, 6'h00, 16'hFFFE, 1, 4, 0, 7, 9, 7'b0100010, 0, 0, 0, 0,
                     4'b0111, 7, 32'hFFFF_FFFE, 9, 4, 0, 5'b00010));
    vecs.push_back(v(1, 6'h3F, 6'h00, 16'h0000, 1, 4, 0, 7, 9, 7'b0011010, 0, 0, 0, 0,
                     4'b1111, 7, 9, 9, 4, 1, 5'b00000));
    vecs.push_back(v(1, 6'h00, 6'h00, 16'h0000, 1, 2, 3, 1, 2, 7'b1000010, 0, 0, 0, 0,
                     4'b1111, 1, 2, 2, 3, 1, 5'b00000));
    vecs.push_back(v(0, 6'h00, 6'h22, 16'h0000, 8, 9, 10, 10, 3, 7'b1000010, 0, 0, 0, 0,
                     4'b0010, 0, 0, 0, 0, 0, 5'b00000));

    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.exmem_result = 32'h11;
    bus.memwb_result = 32'h22;
    drive(vecs[0]);
    bus.exmem_reg_write = 1'b0;
    bus.memwb_reg_write = 1'b0;

    #12;
    tag = -1;
    chk("reset ex_valid",     32'(bus.ex_valid),     32'd0);
    chk("reset ex_alu_ctrl",  32'(bus.ex_alu_ctrl),  32'b0010);
    chk("reset ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
    chk("reset ex_a",         bus.ex_a,              32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      tag = i;
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_vec(vecs[i]);
    end

    // stall: load sub, then hold for two edges while ID presents addi
    tag = 100;
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #1;
    check_vec(vecs[0]);
    @(negedge clk);
    drive(vecs[2]);
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tag = 101 + k;
      @(posedge clk);
      #1;
      check_vec(vecs[0]);
    end

    // flush beats stall
    tag = 110;
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush ex_valid",     32'(bus.ex_valid),     32'd0);
    chk("flush ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
    chk("flush ex_mem_write", 32'(bus.ex_mem_write), 32'd0);
    chk("flush ex_alu_ctrl",  32'(bus.ex_alu_ctrl),  32'b0010);
    chk("flush ex_a",         bus.ex_a,              32'd0);

    // asynchronous reset mid-cycle
    tag = 120;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive(vecs[0]);
    @(posedge clk);
    #1;
    chk("preload ex_reg_write", 32'(bus.ex_reg_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
    chk("async ex_valid",     32'(bus.ex_valid),     32'd0);
    chk("async ex_alu_ctrl",  32'(bus.ex_alu_ctrl),  32'b0010);
    chk("async ex_a",         bus.ex_a,              32'd0);
    chk("async ex_write_reg", 32'(bus.ex_write_reg), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
